// File: rtl/oric_key_matrix_if.sv
// Key-event and matrix-scan bundle between user_io, the Oric core and oric_key_matrix.
// Signals: key_strobe/key_pressed/key_extended/key_code in; row_sel/col_mask_n scan in; key_sense/nmi_n/matrix_dbg out.
interface oric_key_matrix_if;
    logic        key_strobe;
    logic        key_pressed;
    logic        key_extended;
    logic [7:0]  key_code;
    logic [2:0]  row_sel;
    logic [7:0]  col_mask_n;
    logic        key_sense;
    logic        nmi_n;
    logic [63:0] matrix_dbg;

    modport master (
        output key_strobe, key_pressed, key_extended, key_code,
        output row_sel, col_mask_n,
        input  key_sense, nmi_n, matrix_dbg
    );

    modport slave (
        input  key_strobe, key_pressed, key_extended, key_code,
        input  row_sel, col_mask_n,
        output key_sense, nmi_n, matrix_dbg
    );
endinterface

// File: rtl/oric_key_matrix.sv
// PS/2 set-2 key events -> Oric 8x8 keyboard matrix, scan sense bit and F10 NMI pulse.
// Ports: clk_sys, reset_n (async active low), kb (slave): key events, row/column scan, sense/NMI/debug outputs.
module oric_key_matrix #(
    parameter int NMI_MIN_CYCLES = 24000,
    parameter bit EXT_KEYS       = 1'b1
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    oric_key_matrix_if.slave   kb
);

    localparam int CW = (NMI_MIN_CYCLES > 1) ? $clog2(NMI_MIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } state_t;

    // {hit, row[2:0], col[2:0]}
    function automatic logic [6:0] lookup(input logic ext, input logic [7:0] code);
        logic [6:0] r;
        r = '0;
        if (ext) begin
            case (code)
                8'h75:   r = {1'b1, 3'd4, 3'd3};
                8'h72:   r = {1'b1, 3'd4, 3'd6};
                8'h6B:   r = {1'b1, 3'd4, 3'd5};
                8'h74:   r = {1'b1, 3'd4, 3'd7};
                default: r = '0;
            endcase
        end else begin
            case (code)
                8'h26:   r = {1'b1, 3'd0, 3'd7};
                8'h22:   r = {1'b1, 3'd0, 3'd6};
                8'h16:   r = {1'b1, 3'd0, 3'd5};
                8'h2A:   r = {1'b1, 3'd0, 3'd3};
                8'h2E:   r = {1'b1, 3'd0, 3'd2};
                8'h31:   r = {1'b1, 3'd0, 3'd1};
                8'h3D:   r = {1'b1, 3'd0, 3'd0};
                8'h23:   r = {1'b1, 3'd1, 3'd7};
                8'h15:   r = {1'b1, 3'd1, 3'd6};
                8'h76:   r = {1'b1, 3'd1, 3'd5};
                8'h2B:   r = {1'b1, 3'd1, 3'd3};
                8'h2D:   r = {1'b1, 3'd1, 3'd2};
                8'h2C:   r = {1'b1, 3'd1, 3'd1};
                8'h3B:   r = {1'b1, 3'd1, 3'd0};
                8'h21:   r = {1'b1, 3'd2, 3'd7};
                8'h1E:   r = {1'b1, 3'd2, 3'd6};
                8'h1A:   r = {1'b1, 3'd2, 3'd5};
                8'h14:   r = {1'b1, 3'd2, 3'd4};
                8'h25:   r = {1'b1, 3'd2, 3'd3};
                8'h32:   r = {1'b1, 3'd2, 3'd2};
                8'h36:   r = {1'b1, 3'd2, 3'd1};
                8'h3A:   r = {1'b1, 3'd2, 3'd0};
                8'h52:   r = {1'b1, 3'd3, 3'd7};
                8'h75:   r = {1'b1, 3'd3, 3'd7};
                8'h5D:   r = {1'b1, 3'd3, 3'd6};
                8'h4E:   r = {1'b1, 3'd3, 3'd3};
                8'h4C:   r = {1'b1, 3'd3, 3'd2};
                8'h46:   r = {1'b1, 3'd3, 3'd1};
                8'h42:   r = {1'b1, 3'd3, 3'd0};
                8'h12:   r = {1'b1, 3'd4, 3'd4};
                8'h49:   r = {1'b1, 3'd4, 3'd2};
                8'h41:   r = {1'b1, 3'd4, 3'd1};
                8'h29:   r = {1'b1, 3'd4, 3'd0};
                8'h54:   r = {1'b1, 3'd5, 3'd7};
                8'h5B:   r = {1'b1, 3'd5, 3'd6};
                8'h66:   r = {1'b1, 3'd5, 3'd5};
                8'h11:   r = {1'b1, 3'd5, 3'd4};
                8'h4D:   r = {1'b1, 3'd5, 3'd3};
                8'h44:   r = {1'b1, 3'd5, 3'd2};
                8'h43:   r = {1'b1, 3'd5, 3'd1};
                8'h3C:   r = {1'b1, 3'd5, 3'd0};
                8'h1D:   r = {1'b1, 3'd6, 3'd7};
                8'h1B:   r = {1'b1, 3'd6, 3'd6};
                8'h1C:   r = {1'b1, 3'd6, 3'd5};
                8'h24:   r = {1'b1, 3'd6, 3'd3};
                8'h34:   r = {1'b1, 3'd6, 3'd2};
                8'h33:   r = {1'b1, 3'd6, 3'd1};
                8'h35:   r = {1'b1, 3'd6, 3'd0};
                8'h55:   r = {1'b1, 3'd7, 3'd7};
                8'h5A:   r = {1'b1, 3'd7, 3'd5};
                8'h59:   r = {1'b1, 3'd7, 3'd4};
                8'h4A:   r = {1'b1, 3'd7, 3'd3};
                8'h45:   r = {1'b1, 3'd7, 3'd2};
                8'h4B:   r = {1'b1, 3'd7, 3'd1};
                8'h3E:   r = {1'b1, 3'd7, 3'd0};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    logic [6:0]  lk;
    logic        s1_valid;
    logic        s1_pressed;
    logic        s1_hit;
    logic [5:0]  s1_idx;
    logic        s1_f10;
    logic [63:0] matrix;
    logic        key_sense_q;
    logic        f10_held;
    logic        f10_make;
    logic        f10_brk;
    logic        held_now;
    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    assign lk = lookup(kb.key_extended, kb.key_code);

    // Stage 1: registered decode
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_pressed <= 1'b0;
            s1_hit     <= 1'b0;
            s1_idx     <= '0;
            s1_f10     <= 1'b0;
        end else begin
            s1_valid   <= kb.key_strobe;
            s1_pressed <= kb.key_pressed;
            s1_hit     <= lk[6] & (EXT_KEYS | ~kb.key_extended);
            s1_idx     <= lk[5:0];
            s1_f10     <= ~kb.key_extended & (kb.key_code == 8'h09);
        end
    end

    // Stage 2: matrix write; scan sense sees the pre-write matrix
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            matrix      <= '0;
            key_sense_q <= 1'b0;
        end else begin
            if (s1_valid && s1_hit)
                matrix[s1_idx] <= s1_pressed;
            key_sense_q <= |(matrix[{kb.row_sel, 3'b000} +: 8] & ~kb.col_mask_n);
        end
    end

    assign f10_make = s1_valid & s1_f10 & s1_pressed;
    assign f10_brk  = s1_valid & s1_f10 & ~s1_pressed;
    // Key state including the event decoded this cycle
    assign held_now = f10_make | (f10_held & ~f10_brk);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            f10_held <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (s1_valid && s1_f10)
                f10_held <= s1_pressed;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (f10_make) begin
                    state_n = HOLD;
                    cnt_n   = CW'(NMI_MIN_CYCLES - 1);
                end
            end
            HOLD: begin
                if (cnt != '0)
                    cnt_n = cnt - 1'b1;
                else
                    state_n = held_now ? WAIT_REL : IDLE;
            end
            WAIT_REL: begin
                if (f10_brk)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign kb.nmi_n      = (state == IDLE);
    assign kb.key_sense  = key_sense_q;
    assign kb.matrix_dbg = matrix;

endmodule
